// File: rtl/ex_mem_pkg.sv
// Shared types for the EX/MEM boundary: funct3 encodings, skid-buffer states
// and the packed entry that travels from execute into memory.
package ex_mem_pkg;

  localparam int XLEN    = 32;
  localparam int ENTRY_RD_W = 5;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [XLEN-1:0]       result;
    logic [XLEN-1:0]       wr_data;
    logic [3:0]            byte_en;
    logic [ENTRY_RD_W-1:0] rd;
    logic [2:0]            funct3;
    logic                  mem_read;
    logic                  mem_write;
    logic                  reg_write;
    logic                  misaligned;
  } entry_t;

endpackage

// File: rtl/ex_mem_stage_store_align.sv
// Combinational store lane alignment: byte enables, replicated write data and
// natural-alignment check for one memory access.
module store_align
  import ex_mem_pkg::*;
(
  input  logic            i_mem_en,
  input  logic [2:0]      i_funct3,
  input  logic [1:0]      i_addr,
  input  logic [XLEN-1:0] i_store_data,
  output logic [3:0]      o_byte_en,
  output logic [XLEN-1:0] o_wr_data,
  output logic            o_misaligned
);

  always_comb begin
    o_byte_en    = 4'b0000;
    o_wr_data    = i_store_data;
    o_misaligned = 1'b0;
    case (i_funct3)
      F3_B, F3_BU: begin
        o_byte_en = 4'b0001 << i_addr;
        o_wr_data = {4{i_store_data[7:0]}};
      end
      F3_H, F3_HU: begin
        o_wr_data = {2{i_store_data[15:0]}};
        if (i_addr[0]) o_misaligned = 1'b1;
        else           o_byte_en    = 4'b0011 << i_addr;
      end
      F3_W: begin
        if (i_addr != 2'b00) o_misaligned = 1'b1;
        else                 o_byte_en    = 4'b1111;
      end
      default: o_misaligned = 1'b1;
    endcase
    // Non-memory ops carry no lanes; a faulting access enables none.
    if (!i_mem_en) begin
      o_byte_en    = 4'b0000;
      o_misaligned = 1'b0;
    end else if (o_misaligned) begin
      o_byte_en = 4'b0000;
    end
  end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM boundary: branch/jump resolution into a registered redirect, store
// alignment at capture, and a 2-entry skid buffer with registered in_ready.
module ex_mem_stage
  import ex_mem_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_WIDTH-1:0]     in_alu_result,
  input  logic [DATA_WIDTH-1:0]     in_store_data,
  input  logic [DATA_WIDTH-1:0]     in_pc_plus4,
  input  logic [DATA_WIDTH-1:0]     in_br_target,
  input  logic [REG_ADDR_WIDTH-1:0] in_rd,
  input  logic [2:0]                in_funct3,
  input  logic                      in_mem_read,
  input  logic                      in_mem_write,
  input  logic                      in_reg_write,
  input  logic                      in_branch,
  input  logic                      in_jump,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_WIDTH-1:0]     out_result,
  output logic [DATA_WIDTH-1:0]     out_wr_data,
  output logic [3:0]                out_byte_en,
  output logic                      out_mem_read,
  output logic                      out_mem_write,
  output logic                      out_reg_write,
  output logic [REG_ADDR_WIDTH-1:0] out_rd,
  output logic [2:0]                out_funct3,
  output logic                      out_misaligned,
  output logic                      redirect_valid,
  output logic [DATA_WIDTH-1:0]     redirect_target
);

  if (DATA_WIDTH != XLEN) begin : g_bad_width
    $error("ex_mem_stage: byte-lane logic requires DATA_WIDTH == 32");
  end
  if (REG_ADDR_WIDTH != ENTRY_RD_W) begin : g_bad_rd
    $error("ex_mem_stage: REG_ADDR_WIDTH must match ENTRY_RD_W");
  end

  state_t                r_state;
  state_t                w_state_nxt;
  entry_t                r_main;
  entry_t                r_skid;
  entry_t                w_new;
  logic                  r_in_ready;
  logic                  r_redirect_valid;
  logic [XLEN-1:0]       r_redirect_target;
  logic                  w_accept;
  logic                  w_xfer;
  logic                  w_out_valid;
  logic                  w_is_branch;
  logic                  w_enq;
  logic                  w_taken;
  logic [3:0]            w_byte_en;
  logic [XLEN-1:0]       w_wr_data;
  logic                  w_misaligned;

  assign w_out_valid = (r_state != S_EMPTY);
  assign w_accept    = in_valid & r_in_ready;
  assign w_xfer      = w_out_valid & out_ready;
  assign w_is_branch = in_branch & ~in_jump;
  // Branches resolve here and never occupy a buffer slot.
  assign w_enq       = w_accept & ~w_is_branch;
  assign w_taken     = w_accept & (in_jump | (w_is_branch & in_alu_result[0]));

  store_align u_align (
    .i_mem_en     (in_mem_read | in_mem_write),
    .i_funct3     (in_funct3),
    .i_addr       (in_alu_result[1:0]),
    .i_store_data (in_store_data),
    .o_byte_en    (w_byte_en),
    .o_wr_data    (w_wr_data),
    .o_misaligned (w_misaligned)
  );

  always_comb begin
    w_new            = '0;
    w_new.result     = in_jump ? in_pc_plus4 : in_alu_result;
    w_new.wr_data    = w_wr_data;
    w_new.byte_en    = w_byte_en;
    w_new.rd         = in_rd;
    w_new.funct3     = in_funct3;
    w_new.mem_read   = in_mem_read  & ~w_misaligned;
    w_new.mem_write  = in_mem_write & ~w_misaligned;
    w_new.reg_write  = in_reg_write & ~w_misaligned;
    w_new.misaligned = w_misaligned;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_EMPTY: if (w_enq) w_state_nxt = S_ONE;
      S_ONE: begin
        if (w_enq && !w_xfer)      w_state_nxt = S_FULL;
        else if (!w_enq && w_xfer) w_state_nxt = S_EMPTY;
      end
      S_FULL:  if (w_xfer) w_state_nxt = S_ONE;
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_EMPTY;
      r_in_ready <= 1'b1;
      r_main     <= '0;
      r_skid     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt != S_FULL);
      if (r_state == S_FULL) begin
        if (w_xfer) r_main <= r_skid;
      end else if (w_enq) begin
        if (r_state == S_ONE && !w_xfer) r_skid <= w_new;
        else                             r_main <= w_new;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_redirect_valid  <= 1'b0;
      r_redirect_target <= '0;
    end else begin
      r_redirect_valid <= w_taken;
      if (w_taken) r_redirect_target <= in_br_target;
    end
  end

  assign in_ready        = r_in_ready;
  assign out_valid       = w_out_valid;
  assign out_result      = r_main.result;
  assign out_wr_data     = r_main.wr_data;
  assign out_byte_en     = r_main.byte_en;
  assign out_mem_read    = r_main.mem_read;
  assign out_mem_write   = r_main.mem_write;
  assign out_reg_write   = r_main.reg_write;
  assign out_rd          = r_main.rd;
  assign out_funct3      = r_main.funct3;
  assign out_misaligned  = r_main.misaligned;
  assign redirect_valid  = r_redirect_valid;
  assign redirect_target = r_redirect_target;

endmodule
